// File: rtl/mbinit_seq_partner.sv
// Partner side of the MBINIT sideband handshake: for each step k wait for
// request 2k+1, then transmit response 2k+2 once the sideband TX is free.
module mbinit_seq_partner #(
   parameter int unsigned MSG_W       = 4,
   parameter int unsigned NUM_STEPS   = 2,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter bit          STRICT      = 1'b0,
   localparam int unsigned STEP_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              i_enable,
   input  logic [MSG_W-1:0]  i_RX_SbMessage,
   input  logic              i_msg_valid,
   input  logic              i_Busy_SideBand,
   input  logic              i_falling_edge_busy,
   output logic [MSG_W-1:0]  o_TX_SbMessage,
   output logic              o_ValidOutData,
   output logic [STEP_W-1:0] o_step,
   output logic              o_end,
   output logic              o_error
);

   localparam int unsigned       TMR_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMR_W-1:0]  TMR_MAX = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_REQ = 3'd1,
      WAIT_BUS = 3'd2,
      SEND     = 3'd3,
      DONE     = 3'd4,
      ERROR    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [TMR_W-1:0]  timer_q, timer_d, timer_inc;
   logic [MSG_W-1:0]  req_code, rsp_code;
   logic              last_step, req_match, timeout_hit;

   assign req_code    = MSG_W'({step_q, 1'b1});
   assign rsp_code    = MSG_W'({step_d, 1'b1}) + MSG_W'(1);
   assign last_step   = (32'(step_q) == NUM_STEPS - 1);
   assign req_match   = i_msg_valid && (i_RX_SbMessage == req_code);
   assign timer_inc   = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(timer_inc) >= TIMEOUT_CYC);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      timer_d = timer_q;
      if (!i_enable) begin
         state_d = IDLE;
         step_d  = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = WAIT_REQ;
               step_d  = '0;
               timer_d = '0;
            end
            WAIT_REQ: begin
               timer_d = timer_inc;
               // A matching request beats both a strict violation and the timeout.
               if (req_match)
                  state_d = WAIT_BUS;
               else if ((STRICT && i_msg_valid) || timeout_hit)
                  state_d = ERROR;
            end
            WAIT_BUS: begin
               if (!i_Busy_SideBand)
                  state_d = SEND;
            end
            SEND: begin
               if (i_falling_edge_busy) begin
                  if (last_step) begin
                     state_d = DONE;
                  end else begin
                     state_d = WAIT_REQ;
                     step_d  = step_q + STEP_W'(1);
                     timer_d = '0;
                  end
               end
            end
            DONE:  state_d = DONE;
            ERROR: state_d = ERROR;
            default: begin
               state_d = IDLE;
               step_d  = '0;
               timer_d = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q        <= IDLE;
         step_q         <= '0;
         timer_q        <= '0;
         o_TX_SbMessage <= '0;
         o_ValidOutData <= 1'b0;
         o_end          <= 1'b0;
         o_error        <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         timer_q        <= timer_d;
         o_TX_SbMessage <= (state_d == SEND) ? rsp_code : '0;
         o_ValidOutData <= (state_d == SEND);
         o_end          <= (state_d == DONE);
         o_error        <= (state_d == ERROR);
      end
   end

   assign o_step = step_q;

endmodule

// File: tb/tb_mbinit_seq_partner.sv
// Scoreboard bench: expected responses queued by stimulus, popped by a monitor
// on each rising edge of valid/end/error; cycle-exact points checked inline.
module tb_mbinit_seq_partner;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       i_enable = 1'b0;
   logic [3:0] i_RX_SbMessage = '0;
   logic       i_msg_valid = 1'b0;
   logic       i_Busy_SideBand = 1'b0;
   logic       i_falling_edge_busy = 1'b0;

   logic [3:0] o_TX_SbMessage, b_TX_SbMessage;
   logic       o_ValidOutData, b_ValidOutData;
   logic       o_step, b_step;
   logic       o_end, b_end;
   logic       o_error, b_error;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] code;
   } ev_t;
   localparam logic [1:0] EV_TX = 2'd0, EV_END = 2'd1, EV_ERR = 2'd2;
   ev_t exp_q[$];

   always #5 CLK = ~CLK;

   mbinit_seq_partner #(.MSG_W(4), .NUM_STEPS(2), .TIMEOUT_CYC(8), .STRICT(1'b0)) dut (
      .CLK(CLK), .rst(rst), .i_enable(i_enable), .i_RX_SbMessage(i_RX_SbMessage),
      .i_msg_valid(i_msg_valid), .i_Busy_SideBand(i_Busy_SideBand),
      .i_falling_edge_busy(i_falling_edge_busy), .o_TX_SbMessage(o_TX_SbMessage),
      .o_ValidOutData(o_ValidOutData), .o_step(o_step), .o_end(o_end), .o_error(o_error));

   mbinit_seq_partner #(.MSG_W(4), .NUM_STEPS(2), .TIMEOUT_CYC(8), .STRICT(1'b1)) dut_strict (
      .CLK(CLK), .rst(rst), .i_enable(i_enable), .i_RX_SbMessage(i_RX_SbMessage),
      .i_msg_valid(i_msg_valid), .i_Busy_SideBand(i_Busy_SideBand),
      .i_falling_edge_busy(i_falling_edge_busy), .o_TX_SbMessage(b_TX_SbMessage),
      .o_ValidOutData(b_ValidOutData), .o_step(b_step), .o_end(b_end), .o_error(b_error));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon_event(input logic [1:0] kind, input logic [3:0] code);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL mon_unexpected: got kind %0d code %0h, expected no event (t=%0t)",
                  kind, code, $time);
      end else begin
         e = exp_q.pop_front();
         chk("mon_event", {26'd0, kind, code}, {26'd0, e.kind, e.code});
      end
   endtask

   logic prev_v = 1'b0, prev_e = 1'b0, prev_x = 1'b0;
   always @(negedge CLK) begin
      if (o_ValidOutData && !prev_v) mon_event(EV_TX, o_TX_SbMessage);
      if (o_end && !prev_e)          mon_event(EV_END, 4'd0);
      if (o_error && !prev_x)        mon_event(EV_ERR, 4'd0);
      prev_v = o_ValidOutData;
      prev_e = o_end;
      prev_x = o_error;
   end

   task automatic push(input logic [1:0] kind, input logic [3:0] code);
      ev_t e;
      e.kind = kind;
      e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start();
      i_enable = 1'b1;
      tick();
   endtask

   task automatic abort();
      i_enable = 1'b0;
      tick();
   endtask

   task automatic send_req(input logic [3:0] code);
      i_msg_valid    = 1'b1;
      i_RX_SbMessage = code;
      tick();
      i_msg_valid    = 1'b0;
      i_RX_SbMessage = '0;
   endtask

   task automatic pulse_fe();
      i_falling_edge_busy = 1'b1;
      tick();
      i_falling_edge_busy = 1'b0;
   endtask

   task automatic wait_valid(input logic [3:0] exp_tx);
      int n = 0;
      while (!o_ValidOutData && n < 20) begin
         tick();
         n++;
      end
      chk("wait_valid", {31'd0, o_ValidOutData}, 32'd1);
      chk("tx_code", {28'd0, o_TX_SbMessage}, {28'd0, exp_tx});
   endtask

   task automatic run_step(input int k, input bit last);
      logic [3:0] req, rsp;
      req = 4'(2 * k + 1);
      rsp = 4'(2 * k + 2);
      push(EV_TX, rsp);
      if (last) push(EV_END, 4'd0);
      send_req(req);
      wait_valid(rsp);
      tick();
      chk("tx_hold", {31'd0, o_ValidOutData}, 32'd1);
      pulse_fe();
      chk("valid_after_fe", {31'd0, o_ValidOutData}, 32'd0);
      if (last) begin
         chk("end_set", {31'd0, o_end}, 32'd1);
         chk("err_clear", {31'd0, o_error}, 32'd0);
      end else begin
         chk("step_adv", {31'd0, o_step}, 32'(k + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk("rst_valid", {31'd0, o_ValidOutData}, 32'd0);
      chk("rst_tx", {28'd0, o_TX_SbMessage}, 32'd0);
      chk("rst_step", {31'd0, o_step}, 32'd0);
      chk("rst_end_err", {30'd0, o_end, o_error}, 32'd0);
      rst = 1'b0;

      // Basic two-step sequence; a busy falling edge outside SEND is ignored.
      start();
      pulse_fe();
      chk("fe_ignored_step", {31'd0, o_step}, 32'd0);
      run_step(0, 1'b0);
      run_step(1, 1'b1);

      // Reset while DONE, then the sequence runs again.
      rst = 1'b1;
      tick();
      chk("rst_done_end", {31'd0, o_end}, 32'd0);
      chk("rst_done_valid", {31'd0, o_ValidOutData}, 32'd0);
      chk("rst_done_step", {31'd0, o_step}, 32'd0);
      rst = 1'b0;
      tick();
      run_step(0, 1'b0);
      run_step(1, 1'b1);
      abort();
      chk("abort_done_end", {31'd0, o_end}, 32'd0);

      // Enable dropped in the middle of step 1 SEND.
      start();
      run_step(0, 1'b0);
      push(EV_TX, 4'd4);
      send_req(4'd3);
      wait_valid(4'd4);
      abort();
      chk("abort_valid", {31'd0, o_ValidOutData}, 32'd0);
      chk("abort_tx", {28'd0, o_TX_SbMessage}, 32'd0);
      chk("abort_step", {31'd0, o_step}, 32'd0);
      start();
      run_step(0, 1'b0);
      run_step(1, 1'b1);
      abort();

      // Sideband busy for 5 cycles after the matching request.
      start();
      push(EV_TX, 4'd2);
      i_Busy_SideBand = 1'b1;
      send_req(4'd1);
      chk("busy_valid_0", {31'd0, o_ValidOutData}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("busy_valid", {31'd0, o_ValidOutData}, 32'd0);
      end
      i_Busy_SideBand = 1'b0;
      tick();
      chk("busy_release_valid", {31'd0, o_ValidOutData}, 32'd1);
      chk("busy_release_tx", {28'd0, o_TX_SbMessage}, 32'd2);
      abort();

      // Unexpected code at step 0: ignored when relaxed, error when strict.
      start();
      i_msg_valid    = 1'b1;
      i_RX_SbMessage = 4'd3;
      tick();
      i_msg_valid    = 1'b0;
      i_RX_SbMessage = '0;
      chk("relaxed_err", {31'd0, o_error}, 32'd0);
      chk("strict_err", {31'd0, b_error}, 32'd1);
      chk("strict_end", {31'd0, b_end}, 32'd0);
      run_step(0, 1'b0);
      abort();

      // Timeout after 8 WAIT_REQ cycles with no request.
      start();
      repeat (7) tick();
      chk("timeout_early", {31'd0, o_error}, 32'd0);
      push(EV_ERR, 4'd0);
      tick();
      chk("timeout_err", {31'd0, o_error}, 32'd1);
      chk("timeout_valid", {31'd0, o_ValidOutData}, 32'd0);
      abort();
      chk("timeout_cleared", {31'd0, o_error}, 32'd0);

      // Request arriving in the 8th WAIT_REQ cycle wins over the timeout.
      start();
      repeat (7) tick();
      push(EV_TX, 4'd2);
      send_req(4'd1);
      chk("late_req_err", {31'd0, o_error}, 32'd0);
      wait_valid(4'd2);
      abort();

      tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
